// File: rtl/ps2_kbd_pkg.sv
// Shared constants, receive FSM states and 7-segment decode
// for the PS/2 keyboard FIFO slave.
package ps2_kbd_pkg;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_LEVEL  = 2'd3;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_PERR = 3;
  localparam int ST_FERR = 4;

  localparam int CT_IRQ_EN = 0;
  localparam int CT_RX_EN  = 1;
  localparam int CT_FLUSH  = 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Active-low segments, bit order gfedcba
  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchroniser, kc fall
// detect, start/data/parity/stop FSM and inter-edge timeout.
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       kc,
  input  logic       kd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] kc_sr;
  logic [SYNC_STAGES-1:0] kd_sr;
  logic                   kc_prev;
  logic                   kc_s;
  logic                   kd_s;
  logic                   fall;
  rx_state_t              state;
  rx_state_t              state_n;
  logic [7:0]             sreg;
  logic [2:0]             bitcnt;
  logic                   par_ok;
  logic [TW-1:0]          tmr;
  logic                   tout;

  assign kc_s    = kc_sr[SYNC_STAGES-1];
  assign kd_s    = kd_sr[SYNC_STAGES-1];
  assign fall    = kc_prev & ~kc_s;
  assign tout    = (state != IDLE) && (tmr == TW'(TIMEOUT_CYCLES));
  assign rx_byte = sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_sr   <= '1;
      kd_sr   <= '1;
      kc_prev <= 1'b1;
      state   <= IDLE;
      sreg    <= '0;
      bitcnt  <= '0;
      par_ok  <= 1'b0;
      tmr     <= '0;
    end else begin
      kc_sr   <= {kc_sr[SYNC_STAGES-2:0], kc};
      kd_sr   <= {kd_sr[SYNC_STAGES-2:0], kd};
      kc_prev <= kc_s;
      state   <= state_n;
      if (state == IDLE)
        bitcnt <= '0;
      else if (fall && state == DATA) begin
        sreg   <= {kd_s, sreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && state == PARITY)
        par_ok <= ^{sreg, kd_s};
      if (state == IDLE || fall)
        tmr <= '0;
      else if (!tout)
        tmr <= tmr + TW'(1);
    end
  end

  always_comb begin
    state_n = state;
    if (!rx_en || tout)
      state_n = IDLE;
    else if (fall) begin
      unique case (state)
        IDLE:   if (!kd_s) state_n = DATA;
        DATA:   if (bitcnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_valid = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    if (rx_en) begin
      if (tout)
        frame_err = 1'b1;
      else if (fall && state == STOP) begin
        if (!kd_s)
          frame_err = 1'b1;
        else if (par_ok)
          byte_valid = 1'b1;
        else
          parity_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_fifo_avs.sv
// PS/2 keyboard receiver with scancode FIFO, Avalon-MM regs and IRQ.
// Define KBD_SSEG_EN to drive the last scancode onto coe_sseg0/1.
module ps2_kbd_fifo_avs
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       csi_clk,
  input  logic       csi_reset_n,
  input  logic       avs_s1_cs_n,
  input  logic [1:0] avs_s1_address,
  input  logic       avs_s1_read,
  output logic [7:0] avs_s1_readdata,
  input  logic       avs_s1_write,
  input  logic [7:0] avs_s1_writedata,
  output logic       ins_irq0_irq,
  input  logic       coe_kc,
  input  logic       coe_kd,
  output logic [6:0] coe_sseg0,
  output logic [6:0] coe_sseg1
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          byte_valid;
  logic [7:0]    rx_byte;
  logic          perr_p;
  logic          ferr_p;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          irq_en;
  logic          rx_en;
  logic          ovf;
  logic          perr;
  logic          ferr;
  logic          rd;
  logic          wr;
  logic          w_st;
  logic          flush;
  logic          full;
  logic          not_empty;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  logic [7:0]    rd_mux;
  logic          unused_wd;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (csi_clk),
    .rst_n     (csi_reset_n),
    .rx_en     (rx_en),
    .kc        (coe_kc),
    .kd        (coe_kd),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .parity_err(perr_p),
    .frame_err (ferr_p)
  );

  assign unused_wd = ^avs_s1_writedata[7:5];
  assign rd        = ~avs_s1_cs_n & avs_s1_read;
  assign wr        = ~avs_s1_cs_n & avs_s1_write;
  assign w_st      = wr && avs_s1_address == A_STATUS;
  assign flush     = wr && avs_s1_address == A_CTRL
                     && avs_s1_writedata[CT_FLUSH];
  assign full      = count == CW'(FIFO_DEPTH);
  assign not_empty = count != '0;
  assign do_pop    = rd && avs_s1_address == A_DATA && not_empty;
  // A pop frees the slot a same-cycle push into a full FIFO needs
  assign do_push   = byte_valid && (!full || do_pop) && !flush;
  assign ovf_set   = byte_valid && full && !do_pop && !flush;

  always_ff @(posedge csi_clk) begin
    if (do_push)
      mem[wptr] <= rx_byte;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      irq_en <= 1'b0;
      rx_en  <= 1'b1;
      ovf    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (wr && avs_s1_address == A_CTRL) begin
        irq_en <= avs_s1_writedata[CT_IRQ_EN];
        rx_en  <= avs_s1_writedata[CT_RX_EN];
      end
      ovf  <= ovf_set
              | (ovf & ~(w_st & avs_s1_writedata[ST_OVF]));
      perr <= perr_p
              | (perr & ~(w_st & avs_s1_writedata[ST_PERR]));
      ferr <= ferr_p
              | (ferr & ~(w_st & avs_s1_writedata[ST_FERR]));
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (1'b1)
      avs_s1_address == A_DATA:
        rd_mux = not_empty ? mem[rptr] : 8'h00;
      avs_s1_address == A_STATUS:
        rd_mux = {3'b000, ferr, perr, ovf, full, not_empty};
      avs_s1_address == A_CTRL:
        rd_mux = {6'b0, rx_en, irq_en};
      avs_s1_address == A_LEVEL:
        rd_mux = 8'(count);
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_s1_readdata <= 8'h00;
      ins_irq0_irq    <= 1'b0;
    end else begin
      if (rd)
        avs_s1_readdata <= rd_mux;
      ins_irq0_irq <= irq_en & not_empty;
    end
  end

`ifdef KBD_SSEG_EN
  logic [7:0] last_byte;

  // Survives flush so the display keeps the last key seen
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n)
      last_byte <= 8'h00;
    else if (do_push)
      last_byte <= rx_byte;
  end

  assign coe_sseg0 = hex7seg(last_byte[7:4]);
  assign coe_sseg1 = hex7seg(last_byte[3:0]);
`else
  assign coe_sseg0 = 7'h7F;
  assign coe_sseg1 = 7'h7F;
`endif

endmodule
